pad_cfg_sequencer: RTL and testbench
====================================

// Module: pad_cfg_sequencer
// PURPOSE
//  Owns the per-pad configuration vector that drives the pad frame's pull enables.
//  Software writes a shadow copy through a req/gnt port. A commit then applies every changed pad
//  glitch-free: gate output-enable, wait, swap config, wait, release.
//  Also debounces and latches the two boot-select pads once after reset.
//  Sits between the SoC control register bus and the pad frame.
// PARAMETERS
//  N_PADS       48  number of configurable pads (addresses 0..N_PADS-1)
//  CFG_W        6   config bits per pad (bit 0 = pull disable, active-high)
//  SETTLE_CYC   4   gate/hold cycles on each side of the swap; legal range >=1
//  BOOT_STABLE  8   consecutive identical bootsel samples required; legal range >=2
// PORTS
//  clk_i            in   1               single clock
//  rst_i            in   1               synchronous reset, active-high
//  cfg_req_i        in   1               access request
//  cfg_we_i         in   1               1 = write, 0 = read
//  cfg_addr_i       in   6               pad index
//  cfg_wdata_i      in   CFG_W           write data
//  cfg_gnt_o        out  1               request accepted this cycle
//  cfg_rvalid_o     out  1               response valid, 1 cycle after gnt
//  cfg_rdata_o      out  CFG_W           read data (shadow value)
//  cfg_err_o        out  1               with rvalid: address >= N_PADS
//  commit_i         in   1               apply shadow to active (pulse)
//  busy_o           out  1               sequence in progress
//  commit_done_o    out  1               1-cycle pulse, commit finished
//  pad_cfg_o        out  N_PADS*CFG_W    active config, [N_PADS-1:0][CFG_W-1:0]
//  oe_gate_o        out  N_PADS          1 = functional OE allowed, 0 = forced input
//  bootsel_pad_i    in   2               raw boot-select pad inputs
//  bootsel_o        out  2               latched boot select
//  bootsel_valid_o  out  1               bootsel_o is final
// BEHAVIOUR
//  Reset values
//   - shadow, pad_cfg_o, bootsel_o: 0.
//   - oe_gate_o: all 1.
//   - gnt, rvalid, rdata, err, busy, commit_done, bootsel_valid, pending: 0.
//   - FSM state: IDLE.
//   - Reset mid-sequence aborts it; no commit_done pulse.
//  Bus port
//   - cfg_gnt_o = cfg_req_i & (state==IDLE), combinational.
//   - Writes land in the shadow at the grant edge.
//   - Reads return the shadow value 1 cycle later with rvalid.
//   - Address >= N_PADS: granted; write dropped; read data 0; err=1 with rvalid.
//   - The requester holds req/we/addr/wdata stable until granted.
//  FSM: IDLE -> QUIESCE -> SWAP -> HOLD -> IDLE
//   - IDLE and commit_i (or pending): latch diff[i] = (shadow[i] != pad_cfg_o[i]); clear pending.
//     - If diff == 0: commit_done_o pulses next cycle; state stays IDLE; busy stays 0.
//     - Otherwise enter QUIESCE; busy_o=1 from the next cycle.
//   - QUIESCE: oe_gate_o[i]=0 for every diff[i]; lasts SETTLE_CYC cycles.
//   - SWAP: 1 cycle; pad_cfg_o[i] <= shadow[i] for every diff[i]; gates stay 0.
//   - HOLD: gates stay 0 for SETTLE_CYC cycles.
//     - Then IDLE; gates return to 1; commit_done_o pulses on the same cycle.
//   - busy_o high for exactly 2*SETTLE_CYC+1 cycles.
//   - Pads with diff[i]=0 are never gated and never change.
//  Simultaneous events
//   - Write granted and commit_i in the same IDLE cycle: the write is included in the diff/swap.
//   - commit_i while busy sets pending. On return to IDLE, a new sequence starts the next cycle.
//     Multiple commits while busy collapse into one.
//  Boot select
//   - After reset, sample bootsel_pad_i every cycle.
//   - Count resets to 0 when a sample differs from the previous sample.
//   - When BOOT_STABLE identical samples are seen: latch bootsel_o, set bootsel_valid_o=1.
//   - Frozen until the next rst_i; independent of the config FSM.
// TESTING
//  1. Reset release -> pad_cfg_o=0, oe_gate_o=all 1, busy=0; write addr 5 data 6'h01, read addr 5
//     -> rdata 6'h01 with rvalid 1 cycle after gnt.
//  2. Shadow[5]=1, commit -> oe_gate_o[5]=0 for 9 cycles (SETTLE_CYC=4); pad_cfg_o[5]=1 after
//     cycle 5; other gates stay 1; commit_done 1 pulse.
//  3. Commit with no changes -> commit_done next cycle; busy never 1; oe_gate_o unchanged.
//  4. Commit while busy, plus write to addr 47 attempted -> gnt=0 until IDLE.
//     - Write then lands; second sequence runs automatically and applies it.
//  5. Read addr 50 -> rdata 0, err=1. Write addr 63 -> shadow and pad_cfg_o unchanged.
//  6. bootsel_pad_i toggles for 5 cycles, then holds 2'b10 -> bootsel_valid_o rises after 8 stable
//     samples, bootsel_o=2'b10. Later pad changes are ignored. rst_i asserted mid-QUIESCE -> gates
//     all 1, busy=0 next cycle.

Source files
------------

// File: rtl/pad_cfg_sequencer.sv
// Pad configuration owner: shadow register file behind a req/gnt port, glitch-free
// commit sequencing (gate OE, swap, hold, release) and one-shot boot-select capture.
module pad_cfg_sequencer #(
   parameter int N_PADS      = 48,
   parameter int CFG_W       = 6,
   parameter int SETTLE_CYC  = 4,
   parameter int BOOT_STABLE = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_req_i,
   input  logic                          cfg_we_i,
   input  logic [5:0]                    cfg_addr_i,
   input  logic [CFG_W-1:0]              cfg_wdata_i,
   output logic                          cfg_gnt_o,
   output logic                          cfg_rvalid_o,
   output logic [CFG_W-1:0]              cfg_rdata_o,
   output logic                          cfg_err_o,
   input  logic                          commit_i,
   output logic                          busy_o,
   output logic                          commit_done_o,
   output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
   output logic [N_PADS-1:0]             oe_gate_o,
   input  logic [1:0]                    bootsel_pad_i,
   output logic [1:0]                    bootsel_o,
   output logic                          bootsel_valid_o
);

   localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
   localparam int BOOT_W = $clog2(BOOT_STABLE + 1);

   typedef enum logic [1:0] {IDLE, QUIESCE, SWAP, HOLD} state_t;

   state_t                        state;
   logic [N_PADS-1:0][CFG_W-1:0]  shadow;
   logic [N_PADS-1:0][CFG_W-1:0]  shadow_nxt;
   logic [N_PADS-1:0]             diff;
   logic [N_PADS-1:0]             diff_nxt;
   logic [CNT_W-1:0]              cnt;
   logic                          pending;
   logic                          addr_ok;
   logic                          wr_hit;
   logic [1:0]                    boot_prev;
   logic [BOOT_W-1:0]             boot_cnt;

   assign addr_ok   = ({26'd0, cfg_addr_i} < 32'(N_PADS));
   assign cfg_gnt_o = cfg_req_i & (state == IDLE);
   assign wr_hit    = cfg_gnt_o & cfg_we_i & addr_ok;

   // Diff is taken against the shadow including a write granted in the same cycle.
   always_comb begin
      shadow_nxt = shadow;
      diff_nxt   = '0;
      if (wr_hit)
         shadow_nxt[cfg_addr_i] = cfg_wdata_i;
      for (int i = 0; i < N_PADS; i++)
         diff_nxt[i] = (shadow_nxt[i] != pad_cfg_o[i]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         shadow        <= '0;
         pad_cfg_o     <= '0;
         oe_gate_o     <= '1;
         diff          <= '0;
         cnt           <= '0;
         pending       <= 1'b0;
         busy_o        <= 1'b0;
         commit_done_o <= 1'b0;
         cfg_rvalid_o  <= 1'b0;
         cfg_rdata_o   <= '0;
         cfg_err_o     <= 1'b0;
      end else begin
         commit_done_o <= 1'b0;
         cfg_rvalid_o  <= cfg_gnt_o;
         cfg_err_o     <= cfg_gnt_o & ~addr_ok;
         cfg_rdata_o   <= (cfg_gnt_o & ~cfg_we_i & addr_ok) ? shadow[cfg_addr_i] : '0;
         shadow        <= shadow_nxt;
         if (state != IDLE && commit_i)
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (commit_i || pending) begin
                  pending <= 1'b0;
                  diff    <= diff_nxt;
                  if (diff_nxt == '0) begin
                     commit_done_o <= 1'b1;
                  end else begin
                     state     <= QUIESCE;
                     busy_o    <= 1'b1;
                     oe_gate_o <= ~diff_nxt;
                     cnt       <= CNT_W'(SETTLE_CYC - 1);
                  end
               end
            end
            QUIESCE: begin
               if (cnt == '0)
                  state <= SWAP;
               else
                  cnt <= cnt - 1'b1;
            end
            SWAP: begin
               for (int i = 0; i < N_PADS; i++)
                  if (diff[i])
                     pad_cfg_o[i] <= shadow[i];
               state <= HOLD;
               cnt   <= CNT_W'(SETTLE_CYC - 1);
            end
            HOLD: begin
               if (cnt == '0) begin
                  state         <= IDLE;
                  busy_o        <= 1'b0;
                  oe_gate_o     <= '1;
                  commit_done_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Boot select: count consecutive identical samples, latch once, then freeze.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         boot_prev       <= '0;
         boot_cnt        <= '0;
         bootsel_o       <= '0;
         bootsel_valid_o <= 1'b0;
      end else if (!bootsel_valid_o) begin
         boot_prev <= bootsel_pad_i;
         if (boot_cnt == '0 || bootsel_pad_i != boot_prev) begin
            boot_cnt <= BOOT_W'(1);
         end else if (boot_cnt == BOOT_W'(BOOT_STABLE - 1)) begin
            boot_cnt        <= BOOT_W'(BOOT_STABLE);
            bootsel_o       <= bootsel_pad_i;
            bootsel_valid_o <= 1'b1;
         end else begin
            boot_cnt <= boot_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: bus access, commit sequencing, pending commits,
// out-of-range addresses, boot-select capture and reset abort.
module tb_pad_cfg_sequencer;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_req, cfg_we;
   logic [5:0]       cfg_addr;
   logic [5:0]       cfg_wdata;
   logic             cfg_gnt, cfg_rvalid, cfg_err;
   logic [5:0]       cfg_rdata;
   logic             commit, busy, commit_done;
   logic [47:0][5:0] pad_cfg;
   logic [47:0]      oe_gate;
   logic [1:0]       bootsel_pad, bootsel;
   logic             bootsel_valid;

   int checks = 0;
   int failures = 0;

   logic [47:0][5:0] exp_cfg;
   logic [1:0]       tog [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

   pad_cfg_sequencer dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
      .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
      .commit_i(commit), .busy_o(busy), .commit_done_o(commit_done),
      .pad_cfg_o(pad_cfg), .oe_gate_o(oe_gate),
      .bootsel_pad_i(bootsel_pad), .bootsel_o(bootsel), .bootsel_valid_o(bootsel_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [5:0] addr, input logic [5:0] wd,
                      output logic [5:0] rd, output logic er, output logic rv,
                      output int waited, output logic busy_at_gnt);
      cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
      waited = 0;
      #1;
      while (!cfg_gnt && waited < 40) begin
         step();
         waited++;
      end
      busy_at_gnt = busy;
      if (!cfg_gnt) begin
         chk("gnt_timeout", 0, 1);
         cfg_req = 1'b0; rv = 1'b0; rd = '0; er = 1'b0;
      end else begin
         step();
         cfg_req = 1'b0; cfg_we = 1'b0;
         rv = cfg_rvalid; rd = cfg_rdata; er = cfg_err;
      end
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   initial begin
      logic [5:0] rd;
      logic       er, rv, bg;
      int         w, n, busy_n, gate_n, first_cfg, done_n, done_at, other_bad;

      rst = 1'b1; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
      commit = 0; bootsel_pad = 2'b00; exp_cfg = '0;
      repeat (3) step();

      // 1: reset state, write then read back
      chk("rst_pad_cfg", pad_cfg, '0);
      chk("rst_oe_gate", oe_gate, {48{1'b1}});
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", cfg_rvalid, 0);
      chk("rst_bootvalid", bootsel_valid, 0);
      rst = 1'b0;
      step();
      bus(1'b1, 6'd5, 6'h01, rd, er, rv, w, bg);
      chk("wr5_rvalid", rv, 1);
      bus(1'b0, 6'd5, 6'h00, rd, er, rv, w, bg);
      chk("rd5_wait", w, 0);
      chk("rd5_rvalid", rv, 1);
      chk("rd5_rdata", rd, 6'h01);
      chk("rd5_err", er, 0);

      // 2: commit pad 5, observe sequence timing
      exp_cfg[5] = 6'h01;
      pulse_commit();
      busy_n = 0; gate_n = 0; first_cfg = -1; done_n = 0; done_at = -1; other_bad = 0;
      for (int i = 0; i < 14; i++) begin
         if (busy) busy_n++;
         if (!oe_gate[5]) gate_n++;
         if ((oe_gate | 48'h20) != {48{1'b1}}) other_bad++;
         if (pad_cfg[5] == 6'h01 && first_cfg < 0) first_cfg = i;
         if (commit_done) begin
            done_n++;
            if (done_at < 0) done_at = i;
         end
         step();
      end
      chk("c2_busy_cycles", busy_n, 9);
      chk("c2_gate_cycles", gate_n, 9);
      chk("c2_cfg_at", first_cfg, 5);
      chk("c2_done_count", done_n, 1);
      chk("c2_done_at", done_at, 9);
      chk("c2_other_gates", other_bad, 0);
      chk("c2_pad_cfg", pad_cfg, exp_cfg);

      // 3: commit with nothing changed
      pulse_commit();
      busy_n = 0; done_n = 0; done_at = -1; other_bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy) busy_n++;
         if (oe_gate != {48{1'b1}}) other_bad++;
         if (commit_done) begin
            done_n++;
            if (done_at < 0) done_at = i;
         end
         step();
      end
      chk("c3_busy", busy_n, 0);
      chk("c3_done_count", done_n, 1);
      chk("c3_done_at", done_at, 0);
      chk("c3_gates", other_bad, 0);

      // 4: commit while busy sets pending; blocked write lands and is applied
      bus(1'b1, 6'd10, 6'h03, rd, er, rv, w, bg);
      exp_cfg[10] = 6'h03;
      pulse_commit();
      step();
      step();
      pulse_commit();
      bus(1'b1, 6'd47, 6'h2A, rd, er, rv, w, bg);
      exp_cfg[47] = 6'h2A;
      chk("c4_gnt_wait", w, 6);
      chk("c4_busy_at_gnt", bg, 0);
      chk("c4_pad10", pad_cfg[10], 6'h03);
      chk("c4_rerun_busy", busy, 1);
      chk("c4_gate47", oe_gate[47], 0);
      chk("c4_gate10", oe_gate[10], 1);
      n = 0;
      while (!commit_done && n < 30) begin
         step();
         n++;
      end
      chk("c4_done_seen", commit_done, 1);
      chk("c4_pad_cfg", pad_cfg, exp_cfg);
      chk("c4_gates_back", oe_gate, {48{1'b1}});
      step();
      chk("c4_no_third", busy, 0);

      // 5: out-of-range addresses
      bus(1'b0, 6'd50, 6'h00, rd, er, rv, w, bg);
      chk("c5_rd50_rvalid", rv, 1);
      chk("c5_rd50_rdata", rd, 6'h00);
      chk("c5_rd50_err", er, 1);
      bus(1'b1, 6'd63, 6'h3F, rd, er, rv, w, bg);
      chk("c5_wr63_err", er, 1);
      bus(1'b0, 6'd15, 6'h00, rd, er, rv, w, bg);
      chk("c5_rd15", rd, 6'h00);
      bus(1'b0, 6'd31, 6'h00, rd, er, rv, w, bg);
      chk("c5_rd31", rd, 6'h00);
      bus(1'b0, 6'd47, 6'h00, rd, er, rv, w, bg);
      chk("c5_rd47", rd, 6'h2A);
      chk("c5_rd47_err", er, 0);
      pulse_commit();
      chk("c5_nochange_done", commit_done, 1);
      chk("c5_nochange_busy", busy, 0);
      chk("c5_pad_cfg", pad_cfg, exp_cfg);
      chk("c5_boot_valid", bootsel_valid, 1);
      chk("c5_boot_val", bootsel, 2'b00);

      // 6: boot select capture after a fresh reset, then reset mid-QUIESCE
      rst = 1'b1;
      step();
      step();
      chk("c6_rst_pad_cfg", pad_cfg, '0);
      chk("c6_rst_boot", bootsel_valid, 0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bootsel_pad = tog[k];
         step();
      end
      chk("c6_toggle_invalid", bootsel_valid, 0);
      bootsel_pad = 2'b10;
      n = 0;
      while (!bootsel_valid && n < 30) begin
         step();
         n++;
      end
      chk("c6_boot_latency", n, 8);
      chk("c6_bootsel", bootsel, 2'b10);
      bootsel_pad = 2'b01;
      repeat (12) step();
      chk("c6_boot_frozen", bootsel, 2'b10);
      chk("c6_boot_valid_held", bootsel_valid, 1);

      bus(1'b1, 6'd3, 6'h01, rd, er, rv, w, bg);
      pulse_commit();
      step();
      chk("c6_in_quiesce", oe_gate[3], 0);
      rst = 1'b1;
      step();
      chk("c6_abort_gates", oe_gate, {48{1'b1}});
      chk("c6_abort_busy", busy, 0);
      chk("c6_abort_cfg", pad_cfg, '0);
      rst = 1'b0;
      done_n = 0; busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         if (commit_done) done_n++;
         if (busy) busy_n++;
         step();
      end
      chk("c6_no_done", done_n, 0);
      chk("c6_no_busy", busy_n, 0);
      bus(1'b0, 6'd3, 6'h00, rd, er, rv, w, bg);
      chk("c6_shadow_cleared", rd, 6'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
